// File: rtl/decode_stage.sv
// RV32I instruction decode stage: register file with writeback port and
// same-cycle bypass, instruction decode into the execute control word, a
// one-entry ID/EX register with valid/ready flow control, load-use bubble
// insertion and flush.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PCW  = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [PCW-1:0]  if_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [PCW-1:0]  ex_pc,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [4:0]      ex_aluop,
    output logic            ex_sign,
    output logic [XLEN-1:0] ex_data1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_rs1val,
    output logic [XLEN-1:0] ex_rs2val,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic            ex_jal,
    output logic            ex_jalr,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      aluop;
        logic            sign;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] rs1val;
        logic [XLEN-1:0] rs2val;
        logic [XLEN-1:0] imm;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            illegal;
    } idex_t;

    // Maps funct3 plus the alternate bit (instr[30]) to {sign, aluop}.
    // Immediate adds have no subtract form, so alt is ignored for funct3 000.
    function automatic logic [5:0] alu_map(input logic [2:0] f3, input logic alt,
                                           input logic is_imm);
        logic [4:0] op;
        logic       sgn;
        sgn = 1'b1;
        case (f3)
            3'b000:  op = (alt && !is_imm) ? 5'd1 : 5'd0;
            3'b001:  op = 5'd2;
            3'b010:  op = 5'd8;
            3'b011:  begin op = 5'd8; sgn = 1'b0; end
            3'b100:  op = 5'd3;
            3'b101:  op = alt ? 5'd5 : 5'd4;
            3'b110:  op = 5'd6;
            default: op = 5'd7;
        endcase
        return {sgn, op};
    endfunction

    logic [XLEN-1:0] rf_q [1:31];
    idex_t           idex_q, idex_d, dec;
    logic            valid_q, valid_d;

    logic [6:0]      opc;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_ext;
    logic [5:0]      amap;
    logic            uses_rs1, uses_rs2, stall, accept;

    assign opc    = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign imm_i  = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b  = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                     if_instr[11:8], 1'b0};
    assign imm_u  = {if_instr[31:12], 12'b0};
    assign imm_j  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                     if_instr[30:21], 1'b0};
    assign pc_ext = {{(XLEN-PCW){1'b0}}, if_pc};
    assign amap   = alu_map(if_instr[14:12], if_instr[30], opc == OP_IMM);

    // Register file write port; reset wins over a simultaneous writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // Combinational register reads with x0 forced to zero and writeback bypass.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
        if (rs2 != 5'd0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];
    end

    // Instruction decode into the execute control word.
    always_comb begin
        dec          = '0;
        dec.pc       = if_pc;
        dec.rd       = if_instr[11:7];
        dec.funct3   = if_instr[14:12];
        dec.sign     = 1'b1;
        dec.data1    = rs1_val;
        dec.op2      = rs2_val;
        dec.rs1val   = rs1_val;
        dec.rs2val   = rs2_val;
        case (opc)
            OP_R: begin
                dec.aluop    = amap[4:0];
                dec.sign     = amap[5];
                dec.regwrite = 1'b1;
            end
            OP_IMM: begin
                dec.aluop    = amap[4:0];
                dec.sign     = amap[5];
                dec.imm      = imm_i;
                // Shift immediates carry funct7 in imm[11:5]; op2 gets only the shamt.
                dec.op2      = (if_instr[13:12] == 2'b01) ? {27'b0, if_instr[24:20]} : imm_i;
                dec.regwrite = 1'b1;
            end
            OP_LOAD: begin
                dec.imm      = imm_i;
                dec.op2      = imm_i;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_STORE: begin
                dec.imm      = imm_s;
                dec.op2      = imm_s;
                dec.memwrite = 1'b1;
            end
            OP_BRANCH: begin
                dec.aluop    = 5'd1;
                dec.sign     = !if_instr[13];
                dec.imm      = imm_b;
                dec.branch   = 1'b1;
            end
            OP_LUI: begin
                dec.aluop    = 5'd9;
                dec.imm      = imm_u;
                dec.op2      = imm_u;
                dec.regwrite = 1'b1;
            end
            OP_AUIPC: begin
                dec.data1    = pc_ext;
                dec.imm      = imm_u;
                dec.op2      = imm_u;
                dec.regwrite = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                dec.data1    = pc_ext;
                dec.op2      = 32'd4;
                dec.imm      = (opc == OP_JAL) ? imm_j : imm_i;
                dec.jal      = (opc == OP_JAL);
                dec.jalr     = (opc == OP_JALR);
                dec.regwrite = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Load-use hazard detection and ID/EX next-state selection.
    always_comb begin
        uses_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
        uses_rs2 = (opc == OP_R || opc == OP_STORE || opc == OP_BRANCH);
        stall    = valid_q && idex_q.memread && idex_q.rd != 5'd0 &&
                   ((uses_rs1 && rs1 == idex_q.rd) || (uses_rs2 && rs2 == idex_q.rd));
        if_ready = flush || ((!valid_q || ex_ready) && !stall);
        accept   = if_valid && if_ready && !flush;
        valid_d  = valid_q;
        idex_d   = idex_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            idex_d  = dec;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register; contents hold while execute applies backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idex_q  <= idex_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = idex_q.pc;
    assign ex_rd       = idex_q.rd;
    assign ex_funct3   = idex_q.funct3;
    assign ex_aluop    = idex_q.aluop;
    assign ex_sign     = idex_q.sign;
    assign ex_data1    = idex_q.data1;
    assign ex_op2      = idex_q.op2;
    assign ex_rs1val   = idex_q.rs1val;
    assign ex_rs2val   = idex_q.rs2val;
    assign ex_imm      = idex_q.imm;
    assign ex_regwrite = idex_q.regwrite;
    assign ex_memread  = idex_q.memread;
    assign ex_memwrite = idex_q.memwrite;
    assign ex_branch   = idex_q.branch;
    assign ex_jal      = idex_q.jal;
    assign ex_jalr     = idex_q.jalr;
    assign ex_illegal  = idex_q.illegal;

endmodule
